// File: rtl/ir_assembler_if.sv
// Fetch-side bundle for the instruction-register assembler: byte stream in,
// assembled instruction and status out.
interface ir_assembler_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_BYTES = 2,
    parameter int OPC_W     = 3
);
    localparam int W = DATA_W * NUM_BYTES;

    logic [DATA_W-1:0] data;
    logic              ena;
    logic              clr;
    logic [W-1:0]      opc_iraddr;
    logic [OPC_W-1:0]  opcode;
    logic [W-OPC_W-1:0] iraddr;
    logic              ir_valid;
    logic              ir_done;
    logic [2:0]        byte_cnt;

    modport master (
        output data, ena, clr,
        input  opc_iraddr, opcode, iraddr, ir_valid, ir_done, byte_cnt
    );

    modport slave (
        input  data, ena, clr,
        output opc_iraddr, opcode, iraddr, ir_valid, ir_done, byte_cnt
    );
endinterface

// File: rtl/ir_assembler.sv
// Assembles NUM_BYTES consecutive MSB-first fetches into one instruction
// register and splits it into opcode / address fields.
module ir_assembler #(
    parameter int DATA_W    = 8,
    parameter int NUM_BYTES = 2,
    parameter int OPC_W     = 3
) (
    input logic         clk,
    input logic         rst,
    ir_assembler_if.slave bus
);
    localparam int          W    = DATA_W * NUM_BYTES;
    localparam logic [2:0]  LAST = 3'(NUM_BYTES - 1);

    logic [W-1:0] ir_q,    ir_d;
    logic [2:0]   cnt_q,   cnt_d;
    logic         valid_q, valid_d;
    logic         done_q,  done_d;

    // Next-state: clr aborts, ena captures into the current slot, idle restarts at slot 0
    always_comb begin
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (bus.clr) begin
            ir_d    = '0;
            cnt_d   = 3'd0;
            valid_d = 1'b0;
        end else if (bus.ena) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (cnt_q == 3'(k)) begin
                    ir_d[W-1-k*DATA_W -: DATA_W] = bus.data;
                end else begin
                    ir_d[W-1-k*DATA_W -: DATA_W] = ir_q[W-1-k*DATA_W -: DATA_W];
                end
            end
            // The final-slot test comes first so that a one-slot instruction never clears valid
            if (cnt_q == LAST) begin
                cnt_d   = 3'd0;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end else if (cnt_q == 3'd0) begin
                cnt_d   = cnt_q + 3'd1;
                valid_d = 1'b0;
            end else begin
                cnt_d   = cnt_q + 3'd1;
                valid_d = valid_q;
            end
        end else begin
            cnt_d = 3'd0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q    <= '0;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.opc_iraddr = ir_q;
    assign bus.opcode     = ir_q[W-1 -: OPC_W];
    assign bus.iraddr     = ir_q[W-OPC_W-1:0];
    assign bus.ir_valid   = valid_q;
    assign bus.ir_done    = done_q;
    assign bus.byte_cnt   = cnt_q;
endmodule

// File: tb/tb_ir_assembler.sv
// Directed bench for ir_assembler: three configurations (2, 4 and 1 bytes per
// instruction) checked every cycle against a byte-slot model plus literal pins.
module tb_ir_assembler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    localparam int NB [3] = '{2, 4, 1};

    ir_assembler_if #(.DATA_W(8), .NUM_BYTES(2), .OPC_W(3)) if0 ();
    ir_assembler_if #(.DATA_W(8), .NUM_BYTES(4), .OPC_W(3)) if1 ();
    ir_assembler_if #(.DATA_W(8), .NUM_BYTES(1), .OPC_W(3)) if2 ();

    ir_assembler #(.DATA_W(8), .NUM_BYTES(2), .OPC_W(3)) u0 (.clk(clk), .rst(rst), .bus(if0));
    ir_assembler #(.DATA_W(8), .NUM_BYTES(4), .OPC_W(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
    ir_assembler #(.DATA_W(8), .NUM_BYTES(1), .OPC_W(3)) u2 (.clk(clk), .rst(rst), .bus(if2));

    logic [7:0] data_v [3];
    logic       ena_v  [3];
    logic       clr_v  [3];

    assign if0.data = data_v[0]; assign if0.ena = ena_v[0]; assign if0.clr = clr_v[0];
    assign if1.data = data_v[1]; assign if1.ena = ena_v[1]; assign if1.clr = clr_v[1];
    assign if2.data = data_v[2]; assign if2.ena = ena_v[2]; assign if2.clr = clr_v[2];

    logic [31:0] o_ir [3], o_opc [3], o_adr [3], o_val [3], o_done [3], o_cnt [3];
    assign o_ir[0] = 32'(if0.opc_iraddr); assign o_opc[0] = 32'(if0.opcode); assign o_adr[0] = 32'(if0.iraddr);
    assign o_ir[1] = 32'(if1.opc_iraddr); assign o_opc[1] = 32'(if1.opcode); assign o_adr[1] = 32'(if1.iraddr);
    assign o_ir[2] = 32'(if2.opc_iraddr); assign o_opc[2] = 32'(if2.opcode); assign o_adr[2] = 32'(if2.iraddr);
    assign o_val[0] = 32'(if0.ir_valid); assign o_done[0] = 32'(if0.ir_done); assign o_cnt[0] = 32'(if0.byte_cnt);
    assign o_val[1] = 32'(if1.ir_valid); assign o_done[1] = 32'(if1.ir_done); assign o_cnt[1] = 32'(if1.byte_cnt);
    assign o_val[2] = 32'(if2.ir_valid); assign o_done[2] = 32'(if2.ir_done); assign o_cnt[2] = 32'(if2.byte_cnt);

    int vectors = 0;
    int errors  = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction is an array of byte slots, slot k at the k-th byte from the top
    logic [31:0] m_ir [3];
    int          m_cnt [3];
    bit          m_val [3];
    bit          m_done [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_ir[k] <= 32'd0; m_cnt[k] <= 0; m_val[k] <= 1'b0; m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                automatic logic [31:0] t = m_ir[k];
                automatic int w = 8 * NB[k];
                if (clr_v[k]) begin
                    m_ir[k] <= 32'd0; m_cnt[k] <= 0; m_val[k] <= 1'b0; m_done[k] <= 1'b0;
                end else if (ena_v[k]) begin
                    t[w-1-m_cnt[k]*8 -: 8] = data_v[k];
                    m_ir[k]   <= t;
                    m_cnt[k]  <= (m_cnt[k] + 1) % NB[k];
                    m_done[k] <= (m_cnt[k] == NB[k] - 1);
                    if (m_cnt[k] == NB[k] - 1) m_val[k] <= 1'b1;
                    else if (m_cnt[k] == 0)    m_val[k] <= 1'b0;
                end else begin
                    m_cnt[k] <= 0; m_done[k] <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                automatic int w = 8 * NB[k];
                chk($sformatf("u%0d.opc_iraddr", k), o_ir[k], m_ir[k]);
                chk($sformatf("u%0d.opcode", k), o_opc[k], (m_ir[k] >> (w - 3)) & 32'd7);
                chk($sformatf("u%0d.iraddr", k), o_adr[k], m_ir[k] & ((32'd1 << (w - 3)) - 32'd1));
                chk($sformatf("u%0d.ir_valid", k), o_val[k], 32'(m_val[k]));
                chk($sformatf("u%0d.ir_done", k), o_done[k], 32'(m_done[k]));
                chk($sformatf("u%0d.byte_cnt", k), o_cnt[k], 32'(m_cnt[k]));
            end
        end
    end

    // Drive one cycle on instance k (others idle), then settle just after the edge
    task automatic apply(input int k, input logic e, input logic c, input logic [7:0] d);
        for (int j = 0; j < 3; j++) begin
            ena_v[j] = 1'b0; clr_v[j] = 1'b0; data_v[j] = 8'h00;
        end
        ena_v[k] = e; clr_v[k] = c; data_v[k] = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            ena_v[j] = 1'b0; clr_v[j] = 1'b0; data_v[j] = 8'h00;
        end
        #1 rst = 1'b1;
        #12;
        chk("reset ir", o_ir[0], 32'h0);
        chk("reset cnt", o_cnt[0], 32'h0);
        chk("reset valid", o_val[0], 32'h0);
        rst = 1'b0;
        started = 1'b1;

        // Default two-byte instruction
        apply(0, 1'b1, 1'b0, 8'hA5);
        apply(0, 1'b1, 1'b0, 8'h3C);
        chk("dflt ir", o_ir[0], 32'hA53C);
        chk("dflt opcode", o_opc[0], 32'h5);
        chk("dflt iraddr", o_adr[0], 32'h053C);
        chk("dflt done", o_done[0], 32'h1);
        chk("dflt valid", o_val[0], 32'h1);
        apply(0, 1'b0, 1'b0, 8'h00);
        chk("dflt done drop", o_done[0], 32'h0);
        chk("dflt valid hold", o_val[0], 32'h1);

        // Interrupted fetch restarts at the MSB slot
        apply(0, 1'b1, 1'b0, 8'h12);
        apply(0, 1'b0, 1'b0, 8'hFF);
        apply(0, 1'b1, 1'b0, 8'h34);
        chk("intr slot0", o_ir[0] >> 8, 32'h34);
        chk("intr cnt", o_cnt[0], 32'h1);
        chk("intr valid", o_val[0], 32'h0);
        chk("intr done", o_done[0], 32'h0);

        // clr beats ena
        apply(0, 1'b1, 1'b0, 8'h77);
        apply(0, 1'b1, 1'b1, 8'h99);
        chk("clr ir", o_ir[0], 32'h0);
        chk("clr cnt", o_cnt[0], 32'h0);
        chk("clr valid", o_val[0], 32'h0);

        // Async reset between edges, then a clean instruction
        apply(0, 1'b1, 1'b0, 8'h11);
        #2 rst = 1'b1;
        #1;
        chk("arst ir", o_ir[0], 32'h0);
        chk("arst cnt", o_cnt[0], 32'h0);
        chk("arst done", o_done[0], 32'h0);
        #1 rst = 1'b0;
        apply(0, 1'b1, 1'b0, 8'hDE);
        apply(0, 1'b1, 1'b0, 8'hAD);
        chk("arst dead", o_ir[0], 32'hDEAD);

        // Four-byte instruction, back-to-back bursts
        apply(1, 1'b1, 1'b0, 8'h01);
        apply(1, 1'b1, 1'b0, 8'h02);
        apply(1, 1'b1, 1'b0, 8'h03);
        chk("nb4 no early done", o_done[1], 32'h0);
        apply(1, 1'b1, 1'b0, 8'h04);
        chk("nb4 ir", o_ir[1], 32'h01020304);
        chk("nb4 done", o_done[1], 32'h1);
        chk("nb4 cnt wrap", o_cnt[1], 32'h0);
        apply(1, 1'b1, 1'b0, 8'h05);
        chk("nb4 valid drop", o_val[1], 32'h0);
        chk("nb4 done once", o_done[1], 32'h0);
        apply(1, 1'b1, 1'b0, 8'h06);
        apply(1, 1'b1, 1'b0, 8'h07);
        apply(1, 1'b1, 1'b0, 8'h08);
        chk("nb4 ir2", o_ir[1], 32'h05060708);

        // One-byte instruction with continuous enable
        apply(2, 1'b1, 1'b0, 8'h5A);
        chk("nb1 ir a", o_ir[2], 32'h5A);
        chk("nb1 done a", o_done[2], 32'h1);
        ena_v[2] = 1'b1; data_v[2] = 8'hC3;
        @(posedge clk); #1;
        chk("nb1 ir b", o_ir[2], 32'hC3);
        chk("nb1 done b", o_done[2], 32'h1);
        chk("nb1 valid", o_val[2], 32'h1);
        apply(2, 1'b0, 1'b0, 8'h00);
        chk("nb1 done drop", o_done[2], 32'h0);

        // A few extra mixed vectors across all instances
        for (int i = 0; i < 12; i++) begin
            apply(i % 3, (i % 5) != 4, (i % 7) == 6, 8'(8'h3B * i + 8'h11));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ir_assembler.md
IR_ASSEMBLER -- requirements
Module: ir_assembler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of one fetched byte/word on data.
REQ-002 SHALL have parameter NUM_BYTES, default 2, meaning number of consecutive fetches that form one instruction (legal range 1..8).
REQ-003 SHALL have parameter OPC_W, default 3, meaning number of MSBs of the instruction treated as opcode (legal range 1..DATA_W*NUM_BYTES-1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data  input  DATA_W  fetched byte, MSB-first order.
REQ-007 SHALL have port ena  input  1  load enable; byte on data is captured on the rising edge when high.
REQ-008 SHALL have port clr  input  1  synchronous abort; discards the partially assembled instruction.
REQ-009 SHALL have port opc_iraddr  output  DATA_W*NUM_BYTES  assembled instruction register.
REQ-010 SHALL have port opcode  output  OPC_W  combinational alias of opc_iraddr top OPC_W bits.
REQ-011 SHALL have port iraddr  output  DATA_W*NUM_BYTES-OPC_W  combinational alias of the remaining low bits.
REQ-012 SHALL have port ir_valid  output  1  level; high while opc_iraddr holds a complete instruction.
REQ-013 SHALL have port ir_done  output  1  one-cycle pulse marking completion of an instruction.
REQ-014 SHALL have port byte_cnt  output  3  index of the next byte slot to be written (0 = MSB slot).

Function
REQ-015 SHALL define W = DATA_W*NUM_BYTES; slot k occupies opc_iraddr[W-1-k*DATA_W -: DATA_W].
REQ-016 SHALL, on an edge with ena=1 and clr=0, write data into slot byte_cnt, leaving other slots unchanged.
REQ-017 SHALL advance byte_cnt by 1 after each capture, wrapping from NUM_BYTES-1 to 0.
REQ-018 SHALL, on capture into slot NUM_BYTES-1, register ir_valid=1 and ir_done=1 in the same edge (visible the cycle after the final byte is presented; latency 1 clock).
REQ-019 SHALL hold ir_done high for exactly one cycle per completed instruction, deasserting on the next edge unless another completion occurs (NUM_BYTES=1 with continuous ena gives ir_done high every cycle).
REQ-020 SHALL clear ir_valid on capture into slot 0 when NUM_BYTES>1 (new instruction begun); ir_valid otherwise holds.
REQ-021 SHALL, on an edge with ena=0, force byte_cnt to 0 and keep opc_iraddr, ir_valid unchanged (interrupted fetch restarts at the MSB slot).
REQ-022 SHALL, on an edge with clr=1, set byte_cnt=0, opc_iraddr=0, ir_valid=0, ir_done=0 regardless of ena (clr has priority over ena).
REQ-023 SHALL not produce X on any output for any legal parameter set; no default/unknown state assignment.
REQ-024 SHALL keep opcode and iraddr purely combinational from opc_iraddr (no added latency).

Reset
REQ-025 SHALL, while rst=1, immediately and asynchronously set opc_iraddr=0, byte_cnt=0, ir_valid=0, ir_done=0.
REQ-026 SHALL abandon any partial instruction on reset; the first capture after rst deasserts goes to slot 0.
REQ-027 SHALL give rst priority over clr and ena.

Verification
REQ-028 SHALL cover defaults: ena=1 with data 0xA5 then 0x3C -> opc_iraddr=0xA53C, opcode=3'b101, iraddr=13'h053C, ir_done high one cycle, ir_valid high.
REQ-029 SHALL cover interruption: ena=1 data 0x12, ena=0 one cycle, ena=1 data 0x34 -> 0x34 lands in slot 0 (opc_iraddr[15:8]=0x34), byte_cnt=1, ir_valid=0, no ir_done.
REQ-030 SHALL cover clr+ena same cycle after first byte 0x77 -> opc_iraddr=0, byte_cnt=0, ir_valid=0; data ignored.
REQ-031 SHALL cover async reset asserted mid-instruction between clock edges -> outputs zero before next edge; next 0xDE,0xAD yields 0xDEAD.
REQ-032 SHALL cover NUM_BYTES=4, DATA_W=8: 0x01,0x02,0x03,0x04 back-to-back -> 0x01020304, ir_done once, byte_cnt wraps to 0; second burst immediately follows with ir_valid dropping after its first byte.
REQ-033 SHALL cover NUM_BYTES=1: continuous ena with 0x5A,0xC3 -> ir_done high both cycles, opc_iraddr follows data with 1-cycle latency.
